alu_core: RTL

Synthesizable ALU that consumes the input transactions produced by the HAVEN ALU sequence (`ACT`/`OP`/`MOVI`/operands) and returns output transactions (`EX_ALU`/`EX_ALU_VLD`). It is the responding end of the ALU interface that the sequence/sequencer drive, and it is the DUT for the ALU verification environment. Single-cycle operations complete in one clock. Multiplication runs on a sequential shift-add unit, and the block holds `ALU_RDY` low while it runs.

---
 rtl/alu_rtl_pkg.sv | 25 ++
 rtl/alu_mult.sv | 52 +++++
 rtl/alu_core.sv | 122 ++++++++++++
 3 files changed

// File: rtl/alu_rtl_pkg.sv
// Shared ALU types: opcodes, operand-B select and control states.
package alu_rtl_pkg;

   localparam int DEF_DATA_WIDTH = 8;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_MULT = 4'd2,  OP_SHL  = 4'd3,
      OP_SHR  = 4'd4,  OP_ROL  = 4'd5,  OP_ROR  = 4'd6,  OP_NOT  = 4'd7,
      OP_AND  = 4'd8,  OP_OR   = 4'd9,  OP_XOR  = 4'd10, OP_NAND = 4'd11,
      OP_NOR  = 4'd12, OP_XNOR = 4'd13, OP_INC  = 4'd14, OP_DEC  = 4'd15
   } alu_op_t;

   typedef enum logic [1:0] {
      MOVI_REG_B  = 2'd0,
      MOVI_MEM    = 2'd1,
      MOVI_IMM    = 2'd2,
      MOVI_REG_B3 = 2'd3
   } alu_movi_t;

   typedef enum logic {
      IDLE     = 1'b0,
      MUL_BUSY = 1'b1
   } alu_state_t;

endpackage

// File: rtl/alu_mult.sv
// Sequential shift-add multiplier: one partial product per cycle, DATA_WIDTH cycles total.
module alu_mult
   import alu_rtl_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [DATA_WIDTH-1:0]   a,
   input  logic [DATA_WIDTH-1:0]   b,
   output logic                    busy,
   output logic                    done,
   output logic [2*DATA_WIDTH-1:0] product
);

   localparam int CW = $clog2(DATA_WIDTH) + 1;
   localparam int XW = 2 * DATA_WIDTH;

   logic [XW-1:0]         acc;
   logic [XW-1:0]         a_sh;
   logic [DATA_WIDTH-1:0] b_sh;
   logic [CW-1:0]         cnt;

   // product already includes the step being taken this cycle, so the final
   // value is available on the same edge busy drops
   assign product = acc + (b_sh[0] ? a_sh : '0);
   assign done    = busy && (cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0;
         cnt  <= '0;
         acc  <= '0;
         a_sh <= '0;
         b_sh <= '0;
      end else if (start) begin
         busy <= 1'b1;
         cnt  <= CW'(DATA_WIDTH - 1);
         acc  <= '0;
         a_sh <= {{DATA_WIDTH{1'b0}}, a};
         b_sh <= b;
      end else if (busy) begin
         acc  <= product;
         a_sh <= a_sh << 1;
         b_sh <= b_sh >> 1;
         cnt  <= cnt - CW'(1);
         if (cnt == '0) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_core.sv
// ALU responder: single-cycle ops registered in one clock, MULT via alu_mult with ALU_RDY held low.
module alu_core
   import alu_rtl_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    ACT,
   input  logic [3:0]              OP,
   input  logic [1:0]              MOVI,
   input  logic [DATA_WIDTH-1:0]   REG_A,
   input  logic [DATA_WIDTH-1:0]   REG_B,
   input  logic [DATA_WIDTH-1:0]   MEM,
   input  logic [DATA_WIDTH-1:0]   IMM,
   output logic                    ALU_RDY,
   output logic [2*DATA_WIDTH-1:0] EX_ALU,
   output logic                    EX_ALU_VLD
);

   localparam int W  = DATA_WIDTH;
   localparam int XW = 2 * DATA_WIDTH;

   alu_state_t    state, state_n;
   logic          rdy_n, vld_n;
   logic [XW-1:0] ex_n;
   logic [W-1:0]  opb;
   logic [XW-1:0] a_ext, b_ext, res;
   logic          accept, mul_start, mul_busy, mul_done;
   logic [XW-1:0] mul_product;
   alu_op_t       op;

   assign op        = alu_op_t'(OP);
   assign accept    = ACT && ALU_RDY && !RST;
   assign mul_start = accept && (op == OP_MULT);
   assign a_ext     = {{W{1'b0}}, REG_A};
   assign b_ext     = {{W{1'b0}}, opb};

   always_comb begin
      case (alu_movi_t'(MOVI))
         MOVI_MEM: opb = MEM;
         MOVI_IMM: opb = IMM;
         default:  opb = REG_B;
      endcase
   end

   // W-bit results are zero-extended; only arithmetic uses the upper half
   always_comb begin
      res = '0;
      case (op)
         OP_ADD:  res = a_ext + b_ext;
         OP_SUB:  res = a_ext - b_ext;
         OP_SHL:  res = {{(W-1){1'b0}}, REG_A, 1'b0};
         OP_SHR:  res = {{W{1'b0}}, 1'b0, REG_A[W-1:1]};
         OP_ROL:  res = {{W{1'b0}}, REG_A[W-2:0], REG_A[W-1]};
         OP_ROR:  res = {{W{1'b0}}, REG_A[0], REG_A[W-1:1]};
         OP_NOT:  res = {{W{1'b0}}, ~REG_A};
         OP_AND:  res = {{W{1'b0}}, REG_A & opb};
         OP_OR:   res = {{W{1'b0}}, REG_A | opb};
         OP_XOR:  res = {{W{1'b0}}, REG_A ^ opb};
         OP_NAND: res = {{W{1'b0}}, ~(REG_A & opb)};
         OP_NOR:  res = {{W{1'b0}}, ~(REG_A | opb)};
         OP_XNOR: res = {{W{1'b0}}, ~(REG_A ^ opb)};
         OP_INC:  res = a_ext + XW'(1);
         OP_DEC:  res = a_ext - XW'(1);
         default: res = '0;
      endcase
   end

   alu_mult #(.DATA_WIDTH(W)) u_mult (
      .clk     (CLK),
      .rst     (RST),
      .start   (mul_start),
      .a       (REG_A),
      .b       (opb),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   always_comb begin
      state_n = state;
      ex_n    = EX_ALU;
      vld_n   = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (op == OP_MULT) begin
                  state_n = MUL_BUSY;
               end else begin
                  ex_n  = res;
                  vld_n = 1'b1;
               end
            end
         end
         MUL_BUSY: begin
            if (mul_done || !mul_busy) begin
               state_n = IDLE;
               ex_n    = mul_product;
               vld_n   = mul_done;
            end
         end
         default: state_n = IDLE;
      endcase
      rdy_n = (state_n == IDLE);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         ALU_RDY    <= 1'b0;
         EX_ALU     <= '0;
         EX_ALU_VLD <= 1'b0;
      end else begin
         state      <= state_n;
         ALU_RDY    <= rdy_n;
         EX_ALU     <= ex_n;
         EX_ALU_VLD <= vld_n;
      end
   end

endmodule
